dir_step_ctrl: RTL and testbench

//  Consumer end of the key-to-direction path. Takes the 2-bit direction code
//  (di) plus a valid strobe from the key encoder and holds a pending heading.
//  On each move tick it commits that heading and advances a head (x,y)

---
 rtl/dir_step_ctrl.sv | 104 ++++++++++
 tb/tb_dir_step_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dir_step_ctrl.sv
// Direction/step controller: latches key-encoder direction requests, rejects
// 180-degree reversals, and advances a wrap-around head position on each move tick.
module dir_step_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int XW       = 5,
    parameter int YW       = 5,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    di,
    input  logic          di_valid,
    input  logic          enable,
    input  logic          restart,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    heading,
    output logic          step,
    output logic          rev_reject
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [XW-1:0] X_MID   = XW'(GRID_W / 2);
    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MID   = YW'(GRID_H / 2);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    // di_valid is a one-cycle strobe with no back-pressure: every strobe is
    // either accepted into pending or dropped with a rev_reject pulse.
    logic [CW-1:0] cnt;
    logic [1:0]    pending;
    logic          is_rev;
    logic          accept;
    logic          tick;
    logic [1:0]    new_dir;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    // Reversal is judged against the committed heading, not against pending.
    assign is_rev  = (di[1] == heading[1]) && (di[0] != heading[0]);
    assign accept  = di_valid && !is_rev;
    assign tick    = enable && (cnt == CNT_MAX);
    assign new_dir = accept ? di : pending;

    always_comb begin
        nx = head_x;
        ny = head_y;
        case (new_dir)
            DIR_UP:    ny = (head_y == '0)    ? Y_MAX : head_y - YW'(1);
            DIR_DOWN:  ny = (head_y == Y_MAX) ? '0    : head_y + YW'(1);
            DIR_LEFT:  nx = (head_x == '0)    ? X_MAX : head_x - XW'(1);
            DIR_RIGHT: nx = (head_x == X_MAX) ? '0    : head_x + XW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_x     <= X_MID;
            head_y     <= Y_MID;
            heading    <= DIR_RIGHT;
            pending    <= DIR_RIGHT;
            step       <= 1'b0;
            rev_reject <= 1'b0;
        end else if (restart) begin
            head_x     <= X_MID;
            head_y     <= Y_MID;
            heading    <= DIR_RIGHT;
            pending    <= DIR_RIGHT;
            step       <= 1'b0;
            rev_reject <= 1'b0;
        end else begin
            rev_reject <= di_valid && is_rev;
            step       <= tick;
            if (tick) begin
                head_x  <= nx;
                head_y  <= ny;
                heading <= new_dir;
                pending <= new_dir;
            end else if (accept) begin
                pending <= di;
            end
        end
    end

endmodule

// File: tb/tb_dir_step_ctrl.sv
// Directed bench for dir_step_ctrl on an 8x4 grid with a 4-cycle move tick.
module tb_dir_step_ctrl;

    localparam int GRID_W   = 8;
    localparam int GRID_H   = 4;
    localparam int XW       = 5;
    localparam int YW       = 5;
    localparam int TICK_DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    di = 2'b00;
    logic          di_valid = 1'b0;
    logic          enable = 1'b0;
    logic          restart = 1'b0;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [1:0]    heading;
    logic          step;
    logic          rev_reject;

    int checks = 0;
    int failures = 0;

    dir_step_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .di(di), .di_valid(di_valid), .enable(enable),
        .restart(restart), .head_x(head_x), .head_y(head_y), .heading(heading),
        .step(step), .rev_reject(rev_reject)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick_clk();
        restart = 1'b0;
    endtask

    task automatic send(input logic [1:0] d);
        di = d;
        di_valid = 1'b1;
        tick_clk();
        di_valid = 1'b0;
    endtask

    // Clocks until step is seen or the budget runs out; returns cycles used.
    task automatic wait_step(input int max, output int n);
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (!step && n < max);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (head_x !== 5'd4) begin failures++; $display("FAIL reset_x got=%0d exp=4", head_x); end
        checks++; if (head_y !== 5'd2) begin failures++; $display("FAIL reset_y got=%0d exp=2", head_y); end
        checks++; if (heading !== 2'b11) begin failures++; $display("FAIL reset_heading got=%b exp=11", heading); end
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
        checks++; if (rev_reject !== 1'b0) begin failures++; $display("FAIL reset_rev got=%b exp=0", rev_reject); end
        rst_n = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_free_run();
        int n;
        logic [XW-1:0] exp_x [4];
        exp_x = '{5'd5, 5'd6, 5'd7, 5'd0};
        for (int k = 0; k < 4; k++) begin
            wait_step(8, n);
            checks++; if (n !== 4) begin failures++; $display("FAIL run_period[%0d] got=%0d exp=4", k, n); end
            checks++; if (head_x !== exp_x[k]) begin failures++; $display("FAIL run_x[%0d] got=%0d exp=%0d", k, head_x, exp_x[k]); end
            checks++; if (head_y !== 5'd2 || heading !== 2'b11) begin failures++; $display("FAIL run_y_hd[%0d] got=%0d/%b exp=2/11", k, head_y, heading); end
        end
        tick_clk();
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL run_step_pulse got=%b exp=0", step); end
    endtask

    task automatic test_reversal();
        int n;
        do_restart();
        send(2'b10);
        checks++; if (rev_reject !== 1'b1) begin failures++; $display("FAIL rev_pulse got=%b exp=1", rev_reject); end
        tick_clk();
        checks++; if (rev_reject !== 1'b0) begin failures++; $display("FAIL rev_pulse_end got=%b exp=0", rev_reject); end
        wait_step(8, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL rev_latency got=%0d exp=2", n); end
        checks++; if (head_x !== 5'd5 || heading !== 2'b11) begin failures++; $display("FAIL rev_move got=%0d/%b exp=5/11", head_x, heading); end
    endtask

    task automatic test_last_wins();
        int n;
        do_restart();
        send(2'b00);
        send(2'b01);
        checks++; if (rev_reject !== 1'b0) begin failures++; $display("FAIL lw_rev got=%b exp=0", rev_reject); end
        wait_step(8, n);
        checks++; if (n !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", n); end
        checks++; if (heading !== 2'b01 || head_y !== 5'd3 || head_x !== 5'd4) begin
            failures++; $display("FAIL lw_move got=%0d,%0d,%b exp=4,3,01", head_x, head_y, heading); end
    endtask

    task automatic test_committed_ref();
        int n;
        do_restart();
        send(2'b00);
        send(2'b10);
        checks++; if (rev_reject !== 1'b1) begin failures++; $display("FAIL cr_rev got=%b exp=1", rev_reject); end
        wait_step(8, n);
        checks++; if (heading !== 2'b00 || head_y !== 5'd1 || head_x !== 5'd4) begin
            failures++; $display("FAIL cr_move got=%0d,%0d,%b exp=4,1,00", head_x, head_y, heading); end
    endtask

    task automatic test_up_wrap();
        int n;
        do_restart();
        send(2'b00);
        wait_step(8, n);
        checks++; if (n !== 3 || head_y !== 5'd1) begin failures++; $display("FAIL up1 got=n%0d y%0d exp=n3 y1", n, head_y); end
        wait_step(8, n);
        checks++; if (head_y !== 5'd0) begin failures++; $display("FAIL up2 got=%0d exp=0", head_y); end
        wait_step(8, n);
        checks++; if (n !== 4 || head_y !== 5'd3 || heading !== 2'b00) begin
            failures++; $display("FAIL up_wrap got=n%0d y%0d h%b exp=n4 y3 h00", n, head_y, heading); end
        send(2'b01);
        checks++; if (rev_reject !== 1'b1) begin failures++; $display("FAIL up_rev_down got=%b exp=1", rev_reject); end
        send(2'b11);
        checks++; if (rev_reject !== 1'b0) begin failures++; $display("FAIL up_acc_right got=%b exp=0", rev_reject); end
        wait_step(8, n);
        checks++; if (n !== 2 || head_x !== 5'd5 || head_y !== 5'd3 || heading !== 2'b11) begin
            failures++; $display("FAIL up_then_right got=n%0d %0d,%0d,%b exp=n2 5,3,11", n, head_x, head_y, heading); end
    endtask

    task automatic test_tick_cycle_req();
        int n;
        do_restart();
        send(2'b00);
        wait_step(8, n);
        send(2'b10);
        wait_step(8, n);
        checks++; if (n !== 3 || head_x !== 5'd3 || heading !== 2'b10) begin
            failures++; $display("FAIL tc_left got=n%0d x%0d h%b exp=n3 x3 h10", n, head_x, heading); end
        repeat (3) tick_clk();
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL tc_pre got=%b exp=0", step); end
        send(2'b01);
        checks++; if (step !== 1'b1 || head_y !== 5'd2 || head_x !== 5'd3 || heading !== 2'b01) begin
            failures++; $display("FAIL tc_same_cycle got=s%b %0d,%0d,%b exp=s1 3,2,01", step, head_x, head_y, heading); end
    endtask

    task automatic test_pause_restart();
        int n;
        int stray;
        do_restart();
        repeat (2) tick_clk();
        enable = 1'b0;
        send(2'b00);
        stray = (step !== 1'b0) ? 1 : 0;
        for (int i = 0; i < 9; i++) begin
            tick_clk();
            if (step !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL pause_steps got=%0d exp=0", stray); end
        checks++; if (head_x !== 5'd4 || head_y !== 5'd2 || heading !== 2'b11) begin
            failures++; $display("FAIL pause_hold got=%0d,%0d,%b exp=4,2,11", head_x, head_y, heading); end
        enable = 1'b1;
        wait_step(8, n);
        checks++; if (n !== 4 || head_y !== 5'd1 || heading !== 2'b00) begin
            failures++; $display("FAIL resume got=n%0d y%0d h%b exp=n4 y1 h00", n, head_y, heading); end
        do_restart();
        repeat (3) tick_clk();
        do_restart();
        checks++; if (step !== 1'b0 || head_x !== 5'd4 || head_y !== 5'd2 || heading !== 2'b11) begin
            failures++; $display("FAIL restart_at_tick got=s%b %0d,%0d,%b exp=s0 4,2,11", step, head_x, head_y, heading); end
        send(2'b00);
        do_restart();
        wait_step(8, n);
        checks++; if (n !== 4 || head_x !== 5'd5 || head_y !== 5'd2 || heading !== 2'b11) begin
            failures++; $display("FAIL restart_discard got=n%0d %0d,%0d,%b exp=n4 5,2,11", n, head_x, head_y, heading); end
        tick_clk();
        send(2'b01);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (step !== 1'b0 || head_x !== 5'd4 || head_y !== 5'd2 || heading !== 2'b11) begin
            failures++; $display("FAIL async_reset got=s%b %0d,%0d,%b exp=s0 4,2,11", step, head_x, head_y, heading); end
        #1 rst_n = 1'b1;
        wait_step(8, n);
        checks++; if (n !== 4 || head_x !== 5'd5 || heading !== 2'b11) begin
            failures++; $display("FAIL after_async got=n%0d x%0d h%b exp=n4 x5 h11", n, head_x, heading); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_reversal();
        test_last_wins();
        test_committed_ref();
        test_up_wrap();
        test_tick_cycle_req();
        test_pause_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
